// File: rtl/sram_ctrl.sv
// Request/acknowledge front end for a bank of asynchronous SRAM chips.
// Generates registered CE/OE/WE/byte-lane strobes with programmable wait states and read turnaround.
module sram_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int BANKS   = 2,
  parameter int BANK_W  = 1,
  parameter int WAIT_RD = 2,
  parameter int WAIT_WR = 2,
  parameter int TURN    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     we,
  input  logic [BANK_W+ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      be,
  output logic                     busy,
  output logic                     ack,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        ram_a,
  output logic [BANKS-1:0]         ram_ce_n,
  output logic [DATA_W/8-1:0]      ram_be_n,
  output logic                     ram_oe_n,
  output logic                     ram_we_n,
  output logic [DATA_W-1:0]        ram_io_out,
  output logic                     ram_io_oe,
  input  logic [DATA_W-1:0]        ram_io_in
);

  localparam int LANES    = DATA_W / 8;
  localparam int WAIT_MAX = (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
  localparam int CNT_MAX  = (WAIT_MAX > TURN) ? WAIT_MAX : TURN;
  localparam int CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RD, S_WR, S_HOLD, S_DONE, S_TURN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_wr;

  // An out-of-range bank index matches no chip, so every CE stays high.
  function automatic logic [BANKS-1:0] bank_ce_n(input logic [BANK_W-1:0] bank);
    logic [BANKS-1:0] ce;
    for (int i = 0; i < BANKS; i++) begin
      ce[i] = (bank != BANK_W'(i));
    end
    return ce;
  endfunction

  function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] lanes);
    logic [DATA_W-1:0] m;
    for (int k = 0; k < LANES; k++) begin
      m[8*k +: 8] = {8{lanes[k]}};
    end
    return m;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      is_wr      <= 1'b0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      rdata      <= '0;
      ram_a      <= '0;
      ram_ce_n   <= '1;
      ram_be_n   <= '1;
      ram_oe_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      ram_io_out <= '0;
      ram_io_oe  <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state      <= S_SETUP;
            busy       <= 1'b1;
            is_wr      <= we;
            ram_a      <= addr[ADDR_W-1:0];
            ram_ce_n   <= bank_ce_n(addr[ADDR_W +: BANK_W]);
            ram_be_n   <= ~be;
            ram_io_out <= we ? wdata : '0;
            ram_io_oe  <= we;
          end
        end
        S_SETUP: begin
          if (is_wr) begin
            state    <= S_WR;
            ram_we_n <= 1'b0;
            cnt      <= CNT_W'(WAIT_WR - 1);
          end else begin
            state    <= S_RD;
            ram_oe_n <= 1'b0;
            cnt      <= CNT_W'(WAIT_RD - 1);
          end
        end
        S_RD: begin
          if (cnt == '0) begin
            // Strobes are still valid here, so they qualify the captured lanes and bank.
            rdata    <= ram_io_in & lane_mask(~ram_be_n) & {DATA_W{~&ram_ce_n}};
            state    <= S_DONE;
            ack      <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_ce_n <= '1;
            ram_be_n <= '1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WR: begin
          if (cnt == '0) begin
            state    <= S_HOLD;
            ram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          state     <= S_DONE;
          ack       <= 1'b1;
          ram_ce_n  <= '1;
          ram_be_n  <= '1;
          ram_io_oe <= 1'b0;
        end
        S_DONE: begin
          if (!is_wr && TURN > 0) begin
            state <= S_TURN;
            cnt   <= CNT_W'((TURN > 0) ? TURN - 1 : 0);
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_TURN: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Synchronous, parametrised controller for multi-chip asynchronous SRAM, such as the two 256Kx16 parts on the S3 board.
- Converts a single-clock request/acknowledge bus into correctly timed CE/OE/WE/byte-lane strobes with programmable wait states and bus turnaround.
- Sits between the CPU memory port and the board pins; the top level owns the tristate buffer.
- Generalises to N banks, any byte-multiple data width, and configurable timing.

Parameters:
- ADDR_W, 18, SRAM word-address width per chip.
- DATA_W, 16, data width; must be a multiple of 8; LANES = DATA_W/8.
- BANKS, 2, number of chips sharing address, data and strobes; each chip has its own CE.
- BANK_W, 1, bank-select bits; must be at least clog2(BANKS), minimum 1.
- WAIT_RD, 2, cycles OE is held low for a read; minimum 1.
- WAIT_WR, 2, cycles WE is held low for a write; minimum 1.
- TURN, 1, idle cycles after a read before the next transaction; 0 is allowed.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  transaction request; level-sensitive.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  BANK_W+ADDR_W  upper BANK_W bits select the bank, lower ADDR_W bits are the word address.
- wdata  in  DATA_W  write data.
- be  in  LANES  byte enables; bit k selects byte k (bits 8k+7:8k).
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid while ack is high.
- ram_a  out  ADDR_W  SRAM address.
- ram_ce_n  out  BANKS  per-chip chip enable, active low.
- ram_be_n  out  LANES  byte-lane enables (ub_n/lb_n), active low.
- ram_oe_n  out  1  output enable, active low.
- ram_we_n  out  1  write enable, active low.
- ram_io_out  out  DATA_W  data driven to the pins.
- ram_io_oe  out  1  1 = pins are driven by the controller.
- ram_io_in  in  DATA_W  data sampled from the pins.

Behaviour:
- Reset, asynchronous and immediate:
  - State IDLE.
  - busy=0, ack=0, rdata=0, ram_a=0.
  - ram_ce_n, ram_be_n, ram_oe_n, ram_we_n all ones.
  - ram_io_oe=0, ram_io_out=0.
  - Reset mid-transaction aborts it at once, including truncating a WE pulse. No ack is issued.
- States: IDLE, SETUP, RD, WR, HOLD, DONE, TURN. A down-counter wide enough for max(WAIT_RD, WAIT_WR, TURN) is used by RD, WR and TURN.
- IDLE:
  - req=1 at an edge latches we, addr, wdata and be, then goes to SETUP.
  - All other inputs are ignored outside IDLE.
- SETUP (1 cycle):
  - ram_a is valid; the selected bank's CE is low; ram_be_n = ~be.
  - On a write, ram_io_oe=1 and ram_io_out=wdata.
  - Next state is RD (read) or WR (write).
- RD (WAIT_RD cycles):
  - ram_oe_n=0.
  - At the edge ending the last RD cycle, rdata is captured from ram_io_in with disabled lanes forced to 0.
  - Next state is DONE.
- WR (WAIT_WR cycles):
  - ram_we_n=0; data is driven.
  - Next state is HOLD.
- HOLD (1 cycle):
  - ram_we_n=1; CE, address and data are held for hold time.
  - Next state is DONE.
- DONE (1 cycle):
  - ack=1; all strobes are inactive; ram_io_oe=0.
  - After a read: go to TURN if TURN>0, else IDLE. After a write: go to IDLE.
- TURN (TURN cycles): all strobes inactive, then IDLE.
- Latency, counted from the edge that accepts req:
  - Read: ack is high in cycle 2+WAIT_RD.
  - Write: ack is high in cycle 3+WAIT_WR.
- Requester handshake: req must be dropped in the ack cycle. If req is still high in IDLE, a new transaction starts; back-to-back transactions are legal.
- Invariants:
  - ram_oe_n and ram_we_n are never both 0.
  - ram_oe_n is never 0 while ram_io_oe=1.
  - At most one ram_ce_n bit is 0.
  - ram_we_n is never 0 in the same cycle as a change of ram_a or ram_ce_n.
- Out-of-range bank (bank index ≥ BANKS): full timing runs with no CE asserted; ack is issued and read rdata = 0.
- be = 0: full timing runs with no lanes enabled, so memory is unchanged; a read returns 0.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset asserted mid-write (during WR) → same cycle: ram_we_n=1, all CE high, ram_io_oe=0, busy=0; no ack ever follows.
- Default parameters, write addr=0x00123 wdata=0xA5C3 be=11 → ram_ce_n=10, WE low exactly 2 cycles, ack in cycle 5; the SRAM model then reads back 0xA5C3 at bank 0, word 0x123.
- Read of bank 1 (addr=0x40123), model returns 0x1234 → ram_ce_n=01, OE low 2 cycles, ack in cycle 4 with rdata=0x1234; 1 TURN cycle before the next accept.
- Read with be=01 from a word holding 0xBEEF → ram_be_n=10, rdata=0x00EF.
- Back-to-back: write 0x5555 then read of the same address, req held high → second accept follows DONE immediately; rdata=0x5555; the invariant checker reports no OE/WE or OE/drive overlap.
- BANKS=3, BANK_W=2, WAIT_RD=3, TURN=0, read of bank 3 → no CE asserted, ack in cycle 5, rdata=0.
